// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC generation, icache request issue, in-flight tracking, ibuf delivery
package fetch_pkg;
   typedef enum logic [5:0] {
      EXC_NONE = 6'h00,
      ADEF     = 6'h08
   } exception_t;
endpackage

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [63:0] resp_data,
   input  logic        bpu_taken1,
   input  logic        bpu_taken2,
   input  logic [31:0] bpu_target1,
   input  logic [31:0] bpu_target2,
   input  logic        ibuf_ready,
   output logic [1:0]  out_size,
   output logic [31:0] out_pc1,
   output logic [31:0] out_inst1,
   output logic [31:0] out_pc2,
   output logic [31:0] out_inst2,
   output logic        out_pred_taken1,
   output logic        out_pred_taken2,
   output logic [31:0] out_pred_target1,
   output logic [31:0] out_pred_target2,
   output logic        out_have_exception,
   output exception_t  out_exception_type
);

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  size;
      logic        taken1;
      logic [31:0] target1;
      logic        taken2;
      logic [31:0] target2;
   } entry_t;

   logic [31:0] pc;
   logic [1:0]  inflight_count;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  discard;
   logic        halt;
   entry_t      queue [2];

   logic [1:0]  fetch_size;
   logic [31:0] next_pc;
   logic        push;
   logic        pop;
   logic        deliver;
   logic        exc_fire;
   entry_t      head;

   assign fetch_size = (pc[2] || bpu_taken1) ? 2'd1 : 2'd2;
   assign next_pc    = bpu_taken1                          ? bpu_target1 :
                       (fetch_size == 2'd2 && bpu_taken2)  ? bpu_target2 :
                       (pc & ~32'd7) + 32'd8;

   assign req_valid = !redirect_valid && !halt && pc[1:0] == 2'b00 &&
                      inflight_count < 2'd2 && ibuf_ready;
   assign req_addr  = pc;
   assign push      = req_valid && req_ready;
   assign pop       = resp_valid;
   assign head      = queue[rd_ptr];
   assign deliver   = pop && discard == 2'd0 && !redirect_valid;
   // A misaligned PC only faults once older fetches have drained, keeping delivery in order.
   assign exc_fire  = !redirect_valid && !halt && pc[1:0] != 2'b00 &&
                      inflight_count == 2'd0 && ibuf_ready;

   always_comb begin
      out_size           = 2'd0;
      out_pc1            = head.pc;
      out_inst1          = head.pc[2] ? resp_data[63:32] : resp_data[31:0];
      out_pc2            = head.pc + 32'd4;
      out_inst2          = resp_data[63:32];
      out_pred_taken1    = head.taken1;
      out_pred_taken2    = head.taken2;
      out_pred_target1   = head.target1;
      out_pred_target2   = head.target2;
      out_have_exception = 1'b0;
      out_exception_type = EXC_NONE;
      if (deliver) begin
         out_size = head.size;
      end else if (exc_fire) begin
         out_size           = 2'd1;
         out_pc1            = pc;
         out_inst1          = 32'h03400000;
         out_have_exception = 1'b1;
         out_exception_type = ADEF;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc             <= RESET_PC;
         inflight_count <= 2'd0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         discard        <= 2'd0;
         halt           <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         inflight_count <= inflight_count + {1'b0, push} - {1'b0, pop};
         // Everything still outstanding after this cycle's pop belongs to the old path.
         if (redirect_valid)
            discard <= inflight_count - {1'b0, pop};
         else if (pop && discard != 2'd0)
            discard <= discard - 2'd1;
         if (redirect_valid) begin
            pc   <= redirect_pc;
            halt <= 1'b0;
         end else begin
            if (push)     pc   <= next_pc;
            if (exc_fire) halt <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         queue[wr_ptr] <= '{pc: pc, size: fetch_size, taken1: bpu_taken1, target1: bpu_target1,
                            taken2: bpu_taken2, target2: bpu_target2};
   end

   resp_needs_request: assert property (@(posedge clk) disable iff (!reset)
      !(resp_valid && inflight_count == 2'd0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h1c000000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        bpu_taken1, bpu_taken2;
   logic [31:0] bpu_target1, bpu_target2;
   logic        ibuf_ready;
   logic [1:0]  out_size;
   logic [31:0] out_pc1, out_inst1, out_pc2, out_inst2;
   logic        out_pred_taken1, out_pred_taken2;
   logic [31:0] out_pred_target1, out_pred_target2;
   logic        out_have_exception;
   exception_t  out_exception_type;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .bpu_taken1(bpu_taken1), .bpu_taken2(bpu_taken2),
      .bpu_target1(bpu_target1), .bpu_target2(bpu_target2),
      .ibuf_ready(ibuf_ready), .out_size(out_size),
      .out_pc1(out_pc1), .out_inst1(out_inst1), .out_pc2(out_pc2), .out_inst2(out_inst2),
      .out_pred_taken1(out_pred_taken1), .out_pred_taken2(out_pred_taken2),
      .out_pred_target1(out_pred_target1), .out_pred_target2(out_pred_target2),
      .out_have_exception(out_have_exception), .out_exception_type(out_exception_type)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  size;
      logic        t1;
      logic [31:0] g1;
      logic        t2;
      logic [31:0] g2;
      bit          stale;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_halt;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      req_ready = 1'b0; resp_valid = 1'b0; resp_data = 64'h0;
      bpu_taken1 = 1'b0; bpu_taken2 = 1'b0; bpu_target1 = 32'h0; bpu_target2 = 32'h0;
      ibuf_ready = 1'b1;
   endtask

   // Called at a negedge with inputs already applied; returns at the following negedge.
   task automatic step();
      bit          e_req, fire, dlv, exc;
      ent_t        e, n;
      logic [1:0]  sz;
      logic [31:0] nxt;
      #1;
      e_req = !redirect_valid && !m_halt && m_pc[1:0] == 2'b00 && mq.size() < 2 && ibuf_ready;
      check_eq("req_valid", req_valid, e_req);
      check_eq("req_addr", req_addr, m_pc);
      fire = e_req && req_ready;
      dlv = 0;
      exc = 0;
      if (resp_valid && mq.size() > 0) begin
         e = mq[0];
         dlv = !e.stale && !redirect_valid;
      end
      if (!dlv)
         exc = !redirect_valid && !m_halt && m_pc[1:0] != 2'b00 && mq.size() == 0 && ibuf_ready;
      if (dlv) begin
         check_eq("out_size", out_size, e.size);
         check_eq("out_pc1", out_pc1, e.pc);
         check_eq("out_inst1", out_inst1, e.pc[2] ? resp_data[63:32] : resp_data[31:0]);
         check_eq("out_pc2", out_pc2, e.pc + 32'd4);
         check_eq("out_inst2", out_inst2, resp_data[63:32]);
         check_eq("pred_taken1", out_pred_taken1, e.t1);
         check_eq("pred_target1", out_pred_target1, e.g1);
         check_eq("pred_taken2", out_pred_taken2, e.t2);
         check_eq("pred_target2", out_pred_target2, e.g2);
         check_eq("have_exc", out_have_exception, 1'b0);
      end else if (exc) begin
         check_eq("exc_size", out_size, 2'd1);
         check_eq("exc_pc1", out_pc1, m_pc);
         check_eq("exc_inst1", out_inst1, 32'h03400000);
         check_eq("exc_flag", out_have_exception, 1'b1);
         check_eq("exc_type", out_exception_type, ADEF);
      end else begin
         check_eq("out_size_idle", out_size, 2'd0);
      end
      sz  = (m_pc[2] || bpu_taken1) ? 2'd1 : 2'd2;
      nxt = bpu_taken1 ? bpu_target1 : (sz == 2'd2 && bpu_taken2) ? bpu_target2 : (m_pc & ~32'd7) + 32'd8;
      @(posedge clk);
      if (resp_valid && mq.size() > 0) void'(mq.pop_front());
      if (fire) begin
         n = '{pc: m_pc, size: sz, t1: bpu_taken1, g1: bpu_target1, t2: bpu_taken2, g2: bpu_target2, stale: 0};
         mq.push_back(n);
      end
      if (redirect_valid) begin
         foreach (mq[i]) mq[i].stale = 1;
         m_pc = redirect_pc;
         m_halt = 0;
      end else begin
         if (fire) m_pc = nxt;
         if (exc) m_halt = 1;
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      idle();
      reset = 1'b0;
      mq.delete();
      m_pc = RST_PC;
      m_halt = 0;
      #1;
      check_eq("rst_addr", req_addr, RST_PC);
      check_eq("rst_size", out_size, 2'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic randomize_inputs();
      idle();
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc = RST_PC + ($urandom_range(0, 255) << 2);
      if ($urandom % 16 == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
      req_ready = ($urandom % 4) != 0;
      resp_valid = mq.size() > 0 && ($urandom % 3) != 0;
      resp_data = {$urandom, $urandom};
      bpu_taken1 = ($urandom % 5) == 0;
      bpu_taken2 = ($urandom % 4) == 0;
      bpu_target1 = RST_PC + ($urandom_range(0, 1023) << 2);
      bpu_target2 = RST_PC + ($urandom_range(0, 1023) << 2);
      if ($urandom % 40 == 0) bpu_target1 = bpu_target1 | 32'h2;
      ibuf_ready = ($urandom % 6) != 0;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      m_pc = RST_PC;
      m_halt = 0;
      repeat (3) @(negedge clk);
      check_eq("reset_pc", req_addr, RST_PC);
      reset = 1'b1;

      // Sequential fetch and pair delivery
      idle(); req_ready = 1;
      #1; check_eq("d_req0_valid", req_valid, 1'b1); check_eq("d_req0_addr", req_addr, 32'h1c000000);
      step();
      idle(); req_ready = 1; resp_valid = 1; resp_data = {32'haaaa_aaaa, 32'hbbbb_bbbb};
      #1;
      check_eq("d_req1_addr", req_addr, 32'h1c000008);
      check_eq("d_pair_size", out_size, 2'd2);
      check_eq("d_pair_pc1", out_pc1, 32'h1c000000);
      check_eq("d_pair_inst1", out_inst1, 32'hbbbb_bbbb);
      check_eq("d_pair_inst2", out_inst2, 32'haaaa_aaaa);
      step();
      // Redirect to odd word: single-slot fetch
      idle(); redirect_valid = 1; redirect_pc = 32'h1c000104; resp_valid = 1;
      #1; check_eq("d_redir_size", out_size, 2'd0); check_eq("d_redir_req", req_valid, 1'b0);
      step();
      idle(); req_ready = 1;
      #1; check_eq("d_odd_addr", req_addr, 32'h1c000104); check_eq("d_odd_valid", req_valid, 1'b1);
      step();
      idle(); resp_valid = 1; resp_data = {32'h1111_1111, 32'h2222_2222};
      #1;
      check_eq("d_odd_size", out_size, 2'd1);
      check_eq("d_odd_inst1", out_inst1, 32'h1111_1111);
      check_eq("d_odd_next", req_addr, 32'h1c000108);
      step();
      // Taken prediction in slot 1
      idle(); redirect_valid = 1; redirect_pc = 32'h1c000000; step();
      idle(); req_ready = 1; bpu_taken1 = 1; bpu_target1 = 32'h1c000200; step();
      idle(); resp_valid = 1; resp_data = {$urandom, $urandom};
      #1;
      check_eq("d_bp_size", out_size, 2'd1);
      check_eq("d_bp_taken", out_pred_taken1, 1'b1);
      check_eq("d_bp_target", out_pred_target1, 32'h1c000200);
      check_eq("d_bp_next", req_addr, 32'h1c000200);
      step();
      // Redirect with two requests outstanding
      idle(); req_ready = 1; step();
      idle(); req_ready = 1; step();
      idle(); redirect_valid = 1; redirect_pc = 32'h1c000400;
      #1; check_eq("d_flush_req", req_valid, 1'b0);
      step();
      idle(); resp_valid = 1; #1; check_eq("d_drop0", out_size, 2'd0); step();
      idle(); resp_valid = 1; #1; check_eq("d_drop1", out_size, 2'd0); step();
      idle(); req_ready = 1; step();
      idle(); resp_valid = 1; resp_data = {$urandom, $urandom};
      #1; check_eq("d_new_size", out_size, 2'd2); check_eq("d_new_pc", out_pc1, 32'h1c000400);
      step();
      // Misaligned PC raises ADEF and halts
      idle(); redirect_valid = 1; redirect_pc = 32'h1c000002; step();
      idle(); req_ready = 1;
      #1;
      check_eq("d_adef_req", req_valid, 1'b0);
      check_eq("d_adef_size", out_size, 2'd1);
      check_eq("d_adef_flag", out_have_exception, 1'b1);
      check_eq("d_adef_type", out_exception_type, ADEF);
      check_eq("d_adef_inst", out_inst1, 32'h03400000);
      step();
      idle(); req_ready = 1;
      #1; check_eq("d_halt_size", out_size, 2'd0); check_eq("d_halt_req", req_valid, 1'b0);
      step();
      idle(); redirect_valid = 1; redirect_pc = 32'h1c000000; step();
      // ibuf backpressure, then reset mid-fetch
      idle(); req_ready = 1; ibuf_ready = 0;
      #1; check_eq("d_ibuf_req", req_valid, 1'b0);
      step();
      idle(); req_ready = 1; ibuf_ready = 0;
      #1; check_eq("d_ibuf_hold", req_addr, 32'h1c000000);
      step();
      idle(); req_ready = 1; step();
      idle(); req_ready = 1; step();
      reset_pulse();
      check_eq("d_rst_mid", req_addr, 32'h1c000000);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom % 700 == 0) begin
            reset_pulse();
         end else begin
            randomize_inputs();
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000: PC after reset.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- redirect_valid  in  1  backend flush/redirect
- redirect_pc  in  32  new fetch PC
- req_valid  out  1  icache request
- req_addr  out  32  request PC, word-aligned
- req_ready  in  1  icache accepts request
- resp_valid  in  1  icache response, in order, not stallable
- resp_data  in  64  {word at addr|4, word at addr&~4}, 8-byte aligned pair
- bpu_taken1, bpu_taken2  in  1 each  prediction for slot 1/2 of current PC
- bpu_target1, bpu_target2  in  32 each  predicted targets
- ibuf_ready  in  1  ibuf can absorb two more entries
- out_size  out  2  entries pushed this cycle (0..2)
- out_pc1, out_inst1, out_pc2, out_inst2  out  32 each
- out_pred_taken1, out_pred_taken2  out  1 each
- out_pred_target1, out_pred_target2  out  32 each
- out_have_exception  out  1
- out_exception_type  out  exception_t

Function
REQ-003 SHALL hold a fetch PC register, a 2-entry in-order in-flight queue {pc, size, taken1, target1, taken2, target2}, a 2-bit discard counter and a halt flag.
REQ-004 SHALL assert req_valid = !redirect_valid && !halt && pc[1:0]==0 && inflight_count<2 && ibuf_ready, with req_addr = pc.
REQ-005 SHALL compute size = 1 if pc[2]==1 or bpu_taken1, else 2.
REQ-006 SHALL compute next PC: bpu_taken1 -> bpu_target1; else size==2 && bpu_taken2 -> bpu_target2; else (pc & ~7) + 8.
REQ-007 On req_valid && req_ready, SHALL push the in-flight entry and load next PC; the PC SHALL hold otherwise.
REQ-008 The queue SHALL pop one entry per resp_valid; resp_valid with an empty queue is illegal and SHALL be flagged by an assertion.
REQ-009 On a popped response with discard==0 and no redirect that cycle, SHALL drive, in the same cycle: out_size = entry size; out_pc1 = entry pc; out_inst1 = pc[2] ? resp_data[63:32] : resp_data[31:0]; out_pc2 = pc+4; out_inst2 = resp_data[63:32]; prediction fields from the entry; out_have_exception = 0.
REQ-010 On a popped response with discard>0, SHALL drop it (out_size=0) and decrement discard.
REQ-011 SHALL drive out_size=0 in every cycle without a delivered response or exception.
REQ-012 If pc[1:0]!=0, halt==0, inflight_count==0 and ibuf_ready, SHALL emit one entry: out_size=1, out_pc1=pc, out_inst1=32'h03400000, out_have_exception=1, out_exception_type=ADEF; then SHALL set halt, and issue no requests until redirect.
REQ-013 On redirect_valid, SHALL load pc <= redirect_pc, clear halt, force out_size=0, issue no request, and set discard <= inflight_count - (resp_valid ? 1 : 0) + discard_dropped_this_cycle adjustment, so every response for a pre-redirect request is dropped.
REQ-014 A redirect SHALL take effect on the next cycle; the first new request SHALL issue in the cycle after redirect_valid at the earliest.
REQ-015 SHALL accept simultaneous push and pop in one cycle; inflight_count SHALL be unchanged.
REQ-016 Queue pointers SHALL wrap modulo 2; inflight_count is 2 bits, range 0..2.
REQ-017 Outputs other than out_size are don't-care when out_size==0.

Reset
REQ-018 While reset==0 (asynchronous assert): pc=RESET_PC, inflight_count=0, pointers=0, discard=0, halt=0.
REQ-019 Reset asserted mid-operation SHALL abandon all in-flight entries; responses after deassertion without a matching request are illegal stimulus.
REQ-020 Deassertion SHALL be synchronous to clk; the first req_valid SHALL be possible on the first rising edge after deassertion.

Verification
REQ-021 After reset, req_ready=1, no prediction: req_addr 1c000000, 1c000008; response data {A,B} -> out_size=2, out_pc1=1c000000, out_inst1=B, out_inst2=A.
REQ-022 redirect_pc=1c000104: request addr 1c000104 size 1; response {X,Y} -> out_size=1, out_inst1=X; next req_addr=1c000108.
REQ-023 bpu_taken1=1, bpu_target1=1c000200 at PC 1c000000 -> out_size=1 with pred fields set; next req_addr=1c000200.
REQ-024 Two requests in flight, redirect to 1c000400 with no response that cycle -> both later responses dropped (out_size=0); first delivered entry has pc 1c000400.
REQ-025 Redirect to 1c000002 -> no icache request; one entry with out_have_exception=1, ADEF, inst 03400000; req_valid stays 0 until next redirect.
REQ-026 ibuf_ready=0 -> req_valid=0 and PC held; reset pulse mid-fetch -> req_addr returns to 1c000000.
